// File: rtl/fingerprint_stats_processing.sv
// Frame statistics for deserialised fingerprint samples: sentinel filtering, min/max tracking,
// sum limit check and a fixed-point mean from a sequential restoring divider.
module fingerprint_stats_processing #(
  parameter int DATA_W       = 8,
  parameter int SAMPLE_COUNT = 50,
  parameter int SUM_W        = 32,
  parameter int FRAC_BITS    = 16,
  parameter int MAX_SUM      = 12750,
  parameter int FILTER_EN    = 1,
  parameter int LO_SENT      = 0,
  parameter int HI_SENT      = (1 << DATA_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic [SUM_W-1:0]  avg_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              done,
  output logic              reject,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int DIV_W  = SUM_W + FRAC_BITS;
  localparam int REM_W  = 16;
  localparam int ITER_W = $clog2(DIV_W + 1);

  localparam logic [REM_W:0]      DIVISOR    = (REM_W + 1)'(SAMPLE_COUNT);
  localparam logic [15:0]         COUNT_LAST = 16'(SAMPLE_COUNT);
  localparam logic [SUM_W-1:0]    MAX_SUM_V  = SUM_W'(MAX_SUM);
  localparam logic [DATA_W-1:0]   LO_V       = DATA_W'(LO_SENT);
  localparam logic [DATA_W-1:0]   HI_V       = DATA_W'(HI_SENT);
  localparam logic [ITER_W-1:0]   ITER_LAST  = ITER_W'(DIV_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CHECK, S_DIVIDE} state_t;

  state_t              state_q;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [15:0]         count_q, count_d;
  logic [DATA_W-1:0]   min_q, min_d, max_q, max_d;
  logic [15:0]         drop_q, drop_d;
  logic [DIV_W-1:0]    quo_q, quo_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [REM_W:0]      rem_shift;
  logic [ITER_W-1:0]   iter_q;
  logic [SUM_W-1:0]    avg_q;
  logic [DATA_W-1:0]   min_out_q, max_out_q;
  logic                done_q, reject_q;
  logic                accept, is_sent;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign is_sent  = (FILTER_EN != 0) && ((in_data == LO_V) || (in_data == HI_V));

  // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
  always_comb begin
    sum_d     = sum_q + SUM_W'(in_data);
    count_d   = count_q + 16'd1;
    min_d     = (in_data < min_q) ? in_data : min_q;
    max_d     = (in_data > max_q) ? in_data : max_q;
    drop_d    = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    // Remainder stays below the divisor (< 2^16), so one extra bit holds the shifted value.
    rem_shift = {rem_q, quo_q[DIV_W-1]};
    if (rem_shift >= DIVISOR) begin
      rem_d = REM_W'(rem_shift - DIVISOR);
      quo_d = {quo_q[DIV_W-2:0], 1'b1};
    end else begin
      rem_d = REM_W'(rem_shift);
      quo_d = {quo_q[DIV_W-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      count_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      drop_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      iter_q    <= '0;
      avg_q     <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
      done_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
        sum_q   <= '0;
        count_q <= '0;
        drop_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              if (is_sent) begin
                drop_q <= drop_d;
              end else begin
                sum_q   <= SUM_W'(in_data);
                count_q <= 16'd1;
                min_q   <= in_data;
                max_q   <= in_data;
                drop_q  <= '0;
                if (SAMPLE_COUNT == 1) begin
                  state_q  <= S_CHECK;
                  reject_q <= (SUM_W'(in_data) > MAX_SUM_V);
                end else begin
                  state_q <= S_ACCUM;
                end
              end
            end
          end
          S_ACCUM: begin
            if (accept) begin
              if (is_sent) begin
                drop_q <= drop_d;
              end else begin
                sum_q   <= sum_d;
                count_q <= count_d;
                min_q   <= min_d;
                max_q   <= max_d;
                // The limit is judged on entry so the reject pulse lines up with the CHECK cycle.
                if (count_d == COUNT_LAST) begin
                  state_q  <= S_CHECK;
                  reject_q <= (sum_d > MAX_SUM_V);
                end
              end
            end
          end
          S_CHECK: begin
            if (reject_q) begin
              state_q <= S_IDLE;
            end else begin
              quo_q   <= {sum_q, {FRAC_BITS{1'b0}}};
              rem_q   <= '0;
              iter_q  <= '0;
              state_q <= S_DIVIDE;
            end
          end
          S_DIVIDE: begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            iter_q <= iter_q + 1'b1;
            if (iter_q == ITER_LAST) begin
              avg_q     <= quo_d[SUM_W-1:0];
              min_out_q <= min_q;
              max_out_q <= max_q;
              done_q    <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign avg_out    = avg_q;
  assign min_out    = min_out_q;
  assign max_out    = max_out_q;
  assign done       = done_q;
  assign reject     = reject_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fingerprint_stats_processing.sv
// Scoreboard bench: two instances (default limit and MAX_SUM=4999) share one stimulus stream,
// a frame-level reference model queues expected pulses, and negedge monitors compare them.
module tb_fingerprint_stats_processing;

  localparam int N      = 50;
  localparam int LAT    = 49;  // done seen (in posedge count) LAT edges after the last accept edge
  localparam int MAX_A  = 12750;
  localparam int MAX_B  = 4999;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [31:0] avg;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [15:0] drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_clear = 1'b0;

  logic        rdy_a, done_a, rej_a, busy_a;
  logic [31:0] avg_a;
  logic [7:0]  min_a, max_a;
  logic [15:0] drop_a;
  logic        rdy_b, done_b, rej_b, busy_b;
  logic [31:0] avg_b;
  logic [7:0]  min_b, max_b;
  logic [15:0] drop_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [7:0]  frame[$];
  logic [15:0] drops = '0;
  logic [31:0] last_avg[2];
  logic [7:0]  last_mn[2];
  logic [7:0]  last_mx[2];

  fingerprint_stats_processing dut_a (
    .clk(clk), .rst_n(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
    .clear(in_clear), .avg_out(avg_a), .min_out(min_a), .max_out(max_a), .done(done_a),
    .reject(rej_a), .drop_count(drop_a), .busy(busy_a)
  );

  fingerprint_stats_processing #(.MAX_SUM(MAX_B)) dut_b (
    .clk(clk), .rst_n(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
    .clear(in_clear), .avg_out(avg_b), .min_out(min_b), .max_out(max_b), .done(done_b),
    .reject(rej_b), .drop_count(drop_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_a.delete();
    exp_b.delete();
    frame.delete();
    drops = '0;
    for (int i = 0; i < 2; i++) begin
      last_avg[i] = '0;
      last_mn[i]  = '0;
      last_mx[i]  = '0;
    end
  endtask

  // Frame-level model: collect accepted samples, evaluate the frame when it reaches N samples.
  task automatic model_accept(input logic [7:0] d, input int t);
    longint unsigned s;
    logic [7:0] mn, mx;
    exp_t e;
    if (d == 8'h00 || d == 8'hFF) begin
      if (drops != 16'hFFFF) drops = drops + 16'd1;
      return;
    end
    if (frame.size() == 0) drops = '0;
    frame.push_back(d);
    if (frame.size() < N) return;
    s = 0; mn = 8'hFF; mx = 8'h00;
    foreach (frame[k]) begin
      s += frame[k];
      if (frame[k] < mn) mn = frame[k];
      if (frame[k] > mx) mx = frame[k];
    end
    for (int i = 0; i < 2; i++) begin
      e.is_done = (s <= longint'(i == 0 ? MAX_A : MAX_B));
      e.drop    = drops;
      if (e.is_done) begin
        last_avg[i] = 32'((s << 16) / N);
        last_mn[i]  = mn;
        last_mx[i]  = mx;
        e.cyc = t + LAT;
      end else begin
        e.cyc = t;
      end
      e.avg = last_avg[i];
      e.mn  = last_mn[i];
      e.mx  = last_mx[i];
      if (i == 0) exp_a.push_back(e); else exp_b.push_back(e);
    end
    frame.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!(rdy_a && rdy_b)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("ready_timeout", 64'(n), 64'd0);
        return;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    model_accept(d, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd200;
    frame.delete();
    drops = '0;
    @(negedge clk);
    in_clear = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_a", 64'(exp_a.size()), 64'd0);
    check("drain_b", 64'(exp_b.size()), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_avg_a"}, 64'(avg_a), 64'd0);
    check({tag, "_min_a"}, 64'(min_a), 64'd0);
    check({tag, "_max_a"}, 64'(max_a), 64'd0);
    check({tag, "_drop_a"}, 64'(drop_a), 64'd0);
    check({tag, "_pulse_a"}, 64'({done_a, rej_a}), 64'd0);
    check({tag, "_busy_a"}, 64'(busy_a), 64'd0);
    check({tag, "_busy_b"}, 64'(busy_b), 64'd0);
    check({tag, "_avg_b"}, 64'(avg_b), 64'd0);
  endtask

  task automatic mon(input int i, input logic d, input logic r, input logic rdy, input logic bsy,
                     input logic [31:0] avg, input logic [7:0] mn, input logic [7:0] mx,
                     input logic [15:0] dc);
    exp_t e;
    string p;
    int sz;
    p = (i == 0) ? "A" : "B";
    if (!(d || r)) return;
    if (d && r) check({p, "_done_and_reject"}, 64'd1, 64'd0);
    sz = (i == 0) ? exp_a.size() : exp_b.size();
    if (sz == 0) begin
      check({p, "_unexpected_pulse"}, 64'({d, r}), 64'd0);
      return;
    end
    if (i == 0) e = exp_a.pop_front(); else e = exp_b.pop_front();
    check({p, "_pulse_kind_done"}, 64'(d), 64'(e.is_done));
    check({p, "_pulse_cycle"}, 64'(cyc), 64'(e.cyc));
    check({p, "_avg_out"}, 64'(avg), 64'(e.avg));
    check({p, "_min_out"}, 64'(mn), 64'(e.mn));
    check({p, "_max_out"}, 64'(mx), 64'(e.mx));
    check({p, "_drop_count"}, 64'(dc), 64'(e.drop));
    if (r) check({p, "_ready_in_check"}, 64'({rdy, bsy}), 64'b01);
    else   check({p, "_idle_at_done"}, 64'({rdy, bsy}), 64'b10);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, done_a, rej_a, rdy_a, busy_a, avg_a, min_a, max_a, drop_a);
      mon(1, done_b, rej_b, rdy_b, busy_b, avg_b, min_b, max_b, drop_b);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    check("reset_ready_a", 64'(rdy_a), 64'd1);

    for (int k = 0; k < N; k++) send(8'd100);
    for (int k = 1; k <= N; k++) send(8'(k));
    for (int k = 0; k < N; k++) begin
      send(8'd7);
      if (k < 10) begin
        send(8'h00);
        send(8'hFF);
      end
    end
    drain();

    for (int k = 0; k < N; k++) send(8'd100);
    for (int k = 0; k < N; k++) send(8'd20);
    drain();

    for (int k = 0; k < 30; k++) send(8'd200);
    do_clear();
    for (int k = 0; k < N; k++) send(8'd200);
    drain();

    // Reset in the middle of the divide: no pulse may follow, outputs return to zero.
    for (int k = 0; k < N; k++) send(8'($urandom_range(1, 254)));
    repeat (20) @(negedge clk);
    check("divide_busy_a", 64'(busy_a), 64'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_idle_zero("midreset");
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("postreset_ready_a", 64'(rdy_a), 64'd1);
    for (int k = 0; k < N; k++) send(8'd40);
    drain();

    for (int f = 0; f < 8; f++) begin
      int hi;
      hi = (f % 2 == 0) ? 60 : 255;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
        send(8'($urandom_range(1, hi)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fingerprint_stats_processing.md
Name: fingerprint_stats_processing

Overview:
- Parametrised successor to the fingerprint byte-mean block.
- Accepts an already-deserialised sample stream (valid/ready) and drops configurable sentinel values.
- Accumulates a frame of SAMPLE_COUNT samples while tracking min/max, rejects frames whose sum exceeds MAX_SUM, and computes a fixed-point mean with a sequential restoring divider.
- Sits between the UART receiver and the tarot selection logic; has no internal UART.

Parameters:
DATA_W, 8, sample width in bits.
SAMPLE_COUNT, 50, accepted samples per frame (>=1, < 2^16).
SUM_W, 32, accumulator width and avg_out width.
FRAC_BITS, 16, fractional bits of avg_out. Constraint: SUM_W-FRAC_BITS >= DATA_W.
MAX_SUM, 12750, frames with sum > MAX_SUM are rejected.
FILTER_EN, 1, 1 = drop samples equal to LO_SENT or HI_SENT.
LO_SENT, 0, low sentinel value.
HI_SENT, 2^DATA_W-1, high sentinel value.

Ports:
clk  input  1  single clock.
rst_n  input  1  asynchronous, active-high reset (asserted = 1, despite the name).
in_valid  input  1  sample strobe.
in_data  input  DATA_W  sample value.
in_ready  output  1  high in IDLE and ACCUM.
clear  input  1  synchronous frame abort.
avg_out  output  SUM_W  mean in unsigned Q(SUM_W-FRAC_BITS).FRAC_BITS format.
min_out  output  DATA_W  smallest accepted sample of the last good frame.
max_out  output  DATA_W  largest accepted sample of the last good frame.
done  output  1  one-cycle pulse; result outputs are valid.
reject  output  1  one-cycle pulse; sum exceeded MAX_SUM.
drop_count  output  16  sentinels dropped in the current/last frame, saturating at 0xFFFF.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=1): all outputs and registers 0, state IDLE.
- Accept condition: in_valid & in_ready. A sample is a sentinel if FILTER_EN=1 and in_data equals LO_SENT or HI_SENT. Sentinels are consumed but not summed; they increment drop_count.
- IDLE:
  - First accepted non-sentinel starts a frame: sum=in_data, count=1, min=max=in_data, drop_count=0, state ACCUM.
  - A sentinel in IDLE increments drop_count only.
- ACCUM: each accepted non-sentinel does sum+=in_data (zero-extended to SUM_W), count+=1, and updates min/max. When the sample making count==SAMPLE_COUNT is accepted, the next state is CHECK.
- SAMPLE_COUNT=1: the starting sample goes IDLE -> CHECK directly.
- CHECK (1 cycle), in_ready=0:
  - If sum > MAX_SUM: pulse reject and return to IDLE. avg_out, min_out and max_out are unchanged.
  - Otherwise load dividend={sum, FRAC_BITS zeros}, divisor=SAMPLE_COUNT, and go to DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, SUM_W+FRAC_BITS iterations. Quotient = floor(sum*2^FRAC_BITS / SAMPLE_COUNT), truncated to SUM_W bits (cannot overflow given the width constraint). After the last iteration:
  - register avg_out, min_out and max_out;
  - pulse done for 1 cycle;
  - go to IDLE.
- Latency: the last sample is accepted on edge T. CHECK is active in cycle T+1. done is high in cycle T+2+SUM_W+FRAC_BITS (cycle T+50 for defaults); reject is high in cycle T+1.
- Input while in CHECK or DIVIDE is not accepted (in_ready=0). The upstream must hold the sample or tolerate the loss.
- clear=1 in any state: return to IDLE next edge and zero sum/count/drop_count. No done or reject pulse. Result outputs are retained. clear has priority over a simultaneous sample accept.
- done and reject are never high together. Each pulses at most once per frame.
- Sum cannot wrap given SAMPLE_COUNT*(2^DATA_W-1) < 2^SUM_W; integrators must guarantee this in parameters.
- Reset asserted mid-frame or mid-divide clears everything immediately; no pulses.

Test Plan:
1. Defaults; 50 samples of 100 -> sum 5000, done at T+50 with avg_out=0x00640000, min=max=100, reject never asserted.
2. Defaults; samples 1..50 in order -> sum 1275, avg_out=0x00198000 (25.5), min_out=1, max_out=50.
3. Defaults; 50 samples of 7 interleaved with 0x00 and 0xFF (10 of each) -> drop_count=20, avg_out=0x00070000.
4. MAX_SUM=4999; 50 samples of 100 -> reject pulse at T+1, no done, avg_out keeps its previous value; a following frame of 50x20 gives done with avg_out=0x00140000.
5. Defaults; clear after 30 samples, then 50 samples of 200 -> exactly one done, avg_out=0x00C80000.
6. Reset asserted midway through DIVIDE -> all outputs 0 immediately, busy=0, no done; the next full frame computes correctly.
